// File: rtl/exu_pc_pkg.sv
// Shared encodings for the EXU PC controller: ex_kind values, FSM states and the reset PC.
// The TRAP state exists only when MISALIGN_TRAP_EN is defined.
package exu_pc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [2:0] {
        KIND_SEQ    = 3'd0,
        KIND_JAL    = 3'd1,
        KIND_JALR   = 3'd2,
        KIND_BRANCH = 3'd3,
        KIND_HALT   = 3'd4
    } ex_kind_e;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HALT  = 2'd2
`ifdef MISALIGN_TRAP_EN
        , ST_TRAP = 2'd3
`endif
    } state_e;

    // Instruction fetch targets must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/exu_pc_next.sv
// Combinational next-PC arithmetic: selects the fetch target for the resolved
// instruction kind and produces the pc+4 link value. All sums wrap at 2^XLEN.
module exu_pc_next
    import exu_pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [2:0]      kind,
    input  logic            taken,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link
);

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] rel_pc;
    logic [XLEN-1:0] reg_pc;

    assign seq_pc = pc + XLEN'(4);
    assign rel_pc = pc + imm;
    assign reg_pc = (src1 + imm) & ~XLEN'(1);
    assign link   = seq_pc;

    // NOTE: target gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        target = seq_pc;
        case (kind)
            KIND_JAL:    target = rel_pc;
            KIND_JALR:   target = reg_pc;
            KIND_BRANCH: target = taken ? rel_pc : seq_pc;
            KIND_HALT:   target = pc;
            default:     target = seq_pc;
        endcase
    end

endmodule

// File: rtl/exu_pc_ctrl.sv
// PC sequencer between IFU and EXU: offers one PC, waits for its result, then redirects.
// Define MISALIGN_TRAP_EN to trap on fetch targets that are not word aligned.
module exu_pc_ctrl
    import exu_pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    input  logic            pc_ready,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [2:0]      ex_kind,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_src1,
    input  logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] link_pc,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    input  logic [XLEN-1:0] trap_vec,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_epc,
    output logic [XLEN-1:0] trap_tval,
    output logic            halted
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target;
`ifdef MISALIGN_TRAP_EN
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
`endif

    exu_pc_next #(.XLEN(XLEN)) u_next (
        .pc     (pc_q),
        .kind   (ex_kind),
        .taken  (ex_taken),
        .src1   (ex_src1),
        .imm    (ex_imm),
        .target (target),
        .link   (link_pc)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_valid = 1'b0;
        ex_ready = 1'b0;
`ifdef MISALIGN_TRAP_EN
        epc_d    = epc_q;
        tval_d   = tval_q;
`endif
        case (state_q)
            ST_ISSUE: begin
                pc_valid = 1'b1;
                if (flush) begin
                    pc_d = flush_pc;
                end else if (pc_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                ex_ready = 1'b1;
                // A flush outranks the result of the instruction it squashes.
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = ST_ISSUE;
                end else if (ex_valid) begin
                    if (ex_kind == KIND_HALT) begin
                        state_d = ST_HALT;
`ifdef MISALIGN_TRAP_EN
                    end else if (is_misaligned(target[1:0])) begin
                        epc_d   = pc_q;
                        tval_d  = target;
                        pc_d    = trap_vec;
                        state_d = ST_TRAP;
`endif
                    end else begin
                        pc_d    = target;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
`ifdef MISALIGN_TRAP_EN
            ST_TRAP: begin
                state_d = ST_ISSUE;
            end
`endif
            default: begin
                state_d = ST_ISSUE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ISSUE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc     = pc_q;
    assign halted = (state_q == ST_HALT);

`ifdef MISALIGN_TRAP_EN
    // NOTE: trap capture registers are reset explicitly; software may read them before any trap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epc_q  <= '0;
            tval_q <= '0;
        end else begin
            epc_q  <= epc_d;
            tval_q <= tval_d;
        end
    end

    assign trap_valid = (state_q == ST_TRAP);
    assign trap_epc   = epc_q;
    assign trap_tval  = tval_q;
`else
    logic unused_trap_vec;
    assign unused_trap_vec = ^trap_vec;

    assign trap_valid = 1'b0;
    assign trap_epc   = '0;
    assign trap_tval  = '0;
`endif

endmodule

// File: tb/tb_exu_pc_ctrl.sv
// Self-checking bench for exu_pc_ctrl: a directed vector table plus hand-written
// sequences for reset, halt and misaligned JALR (trap checks follow MISALIGN_TRAP_EN).
module tb_exu_pc_ctrl;
    import exu_pc_pkg::*;

    localparam logic [31:0] TRAP_VEC = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_kind;
    logic        ex_taken;
    logic [31:0] ex_src1;
    logic [31:0] ex_imm;
    logic [31:0] link_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] trap_vec;
    logic        trap_valid;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;
    logic        halted;

    int pass_cnt  = 0;
    int total_cnt = 0;

    exu_pc_ctrl #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_kind    (ex_kind),
        .ex_taken   (ex_taken),
        .ex_src1    (ex_src1),
        .ex_imm     (ex_imm),
        .link_pc    (link_pc),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .trap_vec   (trap_vec),
        .trap_valid (trap_valid),
        .trap_epc   (trap_epc),
        .trap_tval  (trap_tval),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        prdy;
        logic        exv;
        logic [2:0]  kind;
        logic        taken;
        logic [31:0] src1;
        logic [31:0] imm;
        logic        fl;
        logic [31:0] fpc;
        logic [31:0] exp_pc;
        logic        exp_pv;
        logic        exp_er;
        logic        exp_halt;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic prdy, input logic exv, input logic [2:0] kind,
                                input logic taken, input logic [31:0] src1, input logic [31:0] imm,
                                input logic fl, input logic [31:0] fpc, input logic [31:0] exp_pc,
                                input logic exp_pv, input logic exp_er, input logic exp_halt);
        vec_t v;
        v.prdy = prdy;     v.exv = exv;         v.kind = kind;     v.taken = taken;
        v.src1 = src1;     v.imm = imm;         v.fl = fl;         v.fpc = fpc;
        v.exp_pc = exp_pc; v.exp_pv = exp_pv;   v.exp_er = exp_er; v.exp_halt = exp_halt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic idle();
        pc_ready = 1'b0;
        ex_valid = 1'b0;
        ex_kind  = 3'd0;
        ex_taken = 1'b0;
        ex_src1  = 32'h0;
        ex_imm   = 32'h0;
        flush    = 1'b0;
        flush_pc = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(1'b1, 1'b0, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h8000_0000, 1'b0, 1'b1, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h8000_0004, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h8000_0004, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, KIND_JAL,    1'b0, 32'h0,         32'h100,       1'b0, 32'h0,         32'h8000_0004, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b1, 32'h8000_0010, 32'h8000_0010, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h8000_0010, 1'b0, 1'b1, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h8000_0010, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, KIND_BRANCH, 1'b1, 32'h0,         32'hFFFF_FFF0, 1'b0, 32'h0,         32'h8000_0000, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b1, 32'h8000_0010, 32'h8000_0010, 1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h8000_0010, 1'b0, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b1, KIND_BRANCH, 1'b0, 32'h0,         32'hFFFF_FFF0, 1'b0, 32'h0,         32'h8000_0014, 1'b1, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h8000_0014, 1'b0, 1'b1, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, KIND_JAL,    1'b0, 32'h0,         32'h20,        1'b0, 32'h0,         32'h8000_0034, 1'b1, 1'b0, 1'b0);
        vecs[13] = mk(1'b1, 1'b0, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h8000_0034, 1'b0, 1'b1, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, 3'd5,        1'b1, 32'h0,         32'h40,        1'b0, 32'h0,         32'h8000_0038, 1'b1, 1'b0, 1'b0);
        vecs[15] = mk(1'b1, 1'b0, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h8000_0038, 1'b0, 1'b1, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, KIND_JALR,   1'b0, 32'h8000_1001, 32'h10,        1'b0, 32'h0,         32'h8000_1010, 1'b1, 1'b0, 1'b0);
        vecs[17] = mk(1'b1, 1'b0, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b1, 32'h100,       32'h0000_0100, 1'b1, 1'b0, 1'b0);
        vecs[18] = mk(1'b1, 1'b0, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h0000_0100, 1'b0, 1'b1, 1'b0);
        vecs[19] = mk(1'b0, 1'b1, KIND_JAL,    1'b0, 32'h0,         32'h40,        1'b1, 32'h100,       32'h0000_0100, 1'b1, 1'b0, 1'b0);
        vecs[20] = mk(1'b0, 1'b0, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        vecs[21] = mk(1'b1, 1'b0, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
        vecs[22] = mk(1'b0, 1'b1, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h0000_0000, 1'b1, 1'b0, 1'b0);
        vecs[23] = mk(1'b1, 1'b0, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h0000_0000, 1'b0, 1'b1, 1'b0);
        vecs[24] = mk(1'b0, 1'b1, KIND_HALT,   1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h0000_0000, 1'b0, 1'b0, 1'b1);
        vecs[25] = mk(1'b1, 1'b1, KIND_SEQ,    1'b0, 32'h0,         32'h0,         1'b1, 32'h200,       32'h0000_0000, 1'b0, 1'b0, 1'b1);

        trap_vec = TRAP_VEC;
        idle();
        rst = 1'b0;
        tick();
        tick();
        check ("rst pc",        pc,         32'h8000_0000);
        checkb("rst halted",    halted,     1'b0);
        checkb("rst trap_valid", trap_valid, 1'b0);
        check ("rst trap_epc",  trap_epc,   32'h0);
        check ("rst trap_tval", trap_tval,  32'h0);
        rst = 1'b1;
        tick();
        checkb("post-rst pc_valid", pc_valid, 1'b1);
        checkb("post-rst ex_ready", ex_ready, 1'b0);
        check ("post-rst link_pc",  link_pc,  32'h8000_0004);

        for (int i = 0; i < NVEC; i++) begin
            pc_ready = vecs[i].prdy;
            ex_valid = vecs[i].exv;
            ex_kind  = vecs[i].kind;
            ex_taken = vecs[i].taken;
            ex_src1  = vecs[i].src1;
            ex_imm   = vecs[i].imm;
            flush    = vecs[i].fl;
            flush_pc = vecs[i].fpc;
            tick();
            check ($sformatf("v%0d pc", i),       pc,       vecs[i].exp_pc);
            checkb($sformatf("v%0d pc_valid", i), pc_valid, vecs[i].exp_pv);
            checkb($sformatf("v%0d ex_ready", i), ex_ready, vecs[i].exp_er);
            check ($sformatf("v%0d link_pc", i),  link_pc,  vecs[i].exp_pc + 32'd4);
            checkb($sformatf("v%0d halted", i),   halted,   vecs[i].exp_halt);
        end

        // Halt persists over idle cycles; asynchronous reset releases it without a clock edge.
        idle();
        tick();
        checkb("halt sticky", halted, 1'b1);
        rst = 1'b0;
        #1;
        check ("async rst pc",     pc,     32'h8000_0000);
        checkb("async rst halted", halted, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        checkb("rst-from-halt pc_valid", pc_valid, 1'b1);

        // Misaligned JALR target.
        pc_ready = 1'b1;
        tick();
        idle();
        checkb("jalr wait ex_ready", ex_ready, 1'b1);
        check ("jalr link before",   link_pc,  32'h8000_0004);
        ex_valid = 1'b1;
        ex_kind  = KIND_JALR;
        ex_src1  = 32'h8000_1003;
        ex_imm   = 32'h0;
        tick();
        idle();
`ifdef MISALIGN_TRAP_EN
        checkb("trap pulse",     trap_valid, 1'b1);
        check ("trap pc",        pc,         TRAP_VEC);
        check ("trap epc",       trap_epc,   32'h8000_0000);
        check ("trap tval",      trap_tval,  32'h8000_1002);
        checkb("trap pc_valid",  pc_valid,   1'b0);
        tick();
        checkb("trap pulse end", trap_valid, 1'b0);
        checkb("trap->issue",    pc_valid,   1'b1);
        check ("trap epc held",  trap_epc,   32'h8000_0000);
        check ("trap pc held",   pc,         TRAP_VEC);
`else
        check ("jalr pc",         pc,         32'h8000_1002);
        checkb("jalr pc_valid",   pc_valid,   1'b1);
        checkb("jalr no trap",    trap_valid, 1'b0);
        check ("jalr tval tied",  trap_tval,  32'h0);
        check ("jalr link after", link_pc,    32'h8000_1006);
`endif

        // Reset in the middle of an outstanding fetch abandons it.
        pc_ready = 1'b1;
        tick();
        checkb("mid wait ex_ready", ex_ready, 1'b1);
        pc_ready = 1'b0;
        ex_valid = 1'b1;
        ex_kind  = KIND_JAL;
        ex_imm   = 32'h40;
        rst = 1'b0;
        tick();
        check("mid rst pc", pc, 32'h8000_0000);
        rst = 1'b1;
        tick();
        checkb("mid rst pc_valid", pc_valid, 1'b1);
        check ("mid rst ex ignored", pc, 32'h8000_0000);
        checkb("mid rst ex_ready",   ex_ready, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
